// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: n-bit word in over valid/ready, MSB-first bit stream out.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module piso_serializer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] dataIn,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         frame_done
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic parity_q, parity_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t        state_q, state_d;
    logic [n-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_bit;
    logic          ready_raw;
    logic          accept;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        frame_done = 1'b0;
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST);

`ifdef SER_PARITY_EN
        // The parity cycle takes over the refill slot so frames stay gapless.
        ready_raw = (state_q == IDLE) || (state_q == PAR);
`else
        ready_raw = (state_q == IDLE) || last_bit;
`endif
        load_ready = reset && ready_raw;
        accept     = load_valid && load_ready;

        case (state_q)
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[n-1];
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q + CW'(1);
                if (last_bit) begin
`ifdef SER_PARITY_EN
                    state_d = PAR;
`else
                    frame_done = 1'b1;
                    state_d    = IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                ser_valid  = 1'b1;
                ser_out    = parity_q;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
`endif
            default: ;
        endcase

        if (accept) begin
            shreg_d = dataIn;
            cnt_d   = '0;
            state_d = SHIFT;
`ifdef SER_PARITY_EN
            parity_d = ^dataIn;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus pushes expected frame bits, a negedge monitor pops them.
// Honours SER_PARITY_EN the same way as the design (adds the parity trailer to each expected frame).
module tb_piso_serializer;

    localparam int N = 8;
`ifdef SER_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] dataIn;
    logic         load_valid;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         frame_done;

    piso_serializer #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic bit_v;
        logic done_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rem   = 0;     // frame cycles still owed on the serial output
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame is the word's bits MSB first, then optional even parity.
    task automatic push_frame(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--)
            exp_q.push_back('{bit_v: w[i], done_v: (FL == N) && (i == 0)});
`ifdef SER_PARITY_EN
        exp_q.push_back('{bit_v: ^w, done_v: 1'b1});
`endif
    endtask

    task automatic cycle(input logic r, input logic lv, input logic [N-1:0] d);
        logic exp_ready;
        logic acc;
        reset      = r;
        load_valid = lv;
        dataIn     = d;
        #1;
        exp_ready = r && (rem <= 1);
        chk("load_ready", {31'b0, load_ready}, {31'b0, exp_ready});
        acc = lv && exp_ready;
        @(posedge clk);
        if (!r) begin
            rem = 0;
            exp_q.delete();
        end else if (acc) begin
            rem = FL;
            push_frame(d);
        end else if (rem > 0) begin
            rem--;
        end
        mon_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ser_valid", {31'b0, ser_valid}, {31'b0, exp_q.size() > 0});
            if (ser_valid && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ser_out", {31'b0, ser_out}, {31'b0, e.bit_v});
                chk("frame_done", {31'b0, frame_done}, {31'b0, e.done_v});
            end else if (!ser_valid) begin
                chk("idle_ser_out", {31'b0, ser_out}, 32'd0);
                chk("idle_frame_done", {31'b0, frame_done}, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b0; load_valid = 1'b0; dataIn = '0;
        @(posedge clk); #1;
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b0, 8'h00);

        // single frame
        cycle(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < FL + 2; i++) cycle(1'b1, 1'b0, 8'h00);

        // back-to-back: 8'hFF then 8'h00 offered on its refill cycle
        cycle(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < FL - 1; i++) cycle(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < FL + 2; i++) cycle(1'b1, (rem <= 1) && (i == 0) ? 1'b1 : 1'b0, 8'h00);

        // backpressure: 3C held valid across the C3 frame
        cycle(1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < FL + 2; i++) cycle(1'b1, 1'b0, 8'hFF);

        // reset mid-frame, then a clean frame
        cycle(1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h18);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h81);
        for (int i = 0; i < FL + 2; i++) cycle(1'b1, 1'b0, 8'h00);

        // idle stability with dataIn toggling
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, N'($urandom));

        // parity-sensitive words
        cycle(1'b1, 1'b1, 8'h07);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h03);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 8'h00);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), N'($urandom));

        for (int i = 0; i < FL + 4; i++) cycle(1'b1, 1'b0, 8'h00);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
